// File: rtl/spi_slave_out_pkg.sv
// Shared constants for the SPI slave transmitter: idle line levels, FSM encoding
// and default sizing.
package spi_pkg;

  localparam logic SCK_IDLE = 1'b1;
  localparam logic CS_IDLE  = 1'b1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam int DEF_BITS        = 4;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_slave_out_if.sv
// Parallel load channel into the SPI slave transmitter (valid/ready handshake).
interface spi_slave_out_if #(
  parameter int BITS = spi_pkg::DEF_BITS
);

  logic [BITS-1:0] tx_data;
  logic            tx_valid;
  logic            tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/spi_slave_out_sync_edge.sv
// Multi-flop synchroniser with a trailing prev flop, giving the synced level and
// single-clk rise/fall strobes. Flops reset to RESET_VAL so no edge follows reset.
module sync_edge #(
  parameter int   STAGES    = spi_pkg::DEF_SYNC_STAGES,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_out.sv
// SPI slave transmitter (CPOL=1, active-low cs), MSB first, one-deep holding buffer.
// Optional SPI_SLAVE_MISO_INVERT_EN drives miso as the complement of the data bit.
module spi_slave_out
  import spi_pkg::*;
#(
  parameter int BITS        = DEF_BITS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_slave_out_if.slave        tx,
  input  logic                  sck,
  input  logic                  cs,
  output logic                  miso,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun,
  output logic                  abort
);

  localparam int CW = $clog2(BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

`ifdef SPI_SLAVE_MISO_INVERT_EN
  localparam logic MISO_INV = 1'b1;
`else
  localparam logic MISO_INV = 1'b0;
`endif

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SCK_IDLE)) u_sck_sync (
    .clk(clk), .reset(reset), .d(sck),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CS_IDLE)) u_cs_sync (
    .clk(clk), .reset(reset), .d(cs),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  wire unused_sync = &{1'b0, sck_level, sck_fall, cs_level};

  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BITS-1:0] shift_reg_q, shift_reg_d;
  logic [BITS-1:0] hold_data_q, hold_data_d;
  logic            hold_full_q, hold_full_d;
  logic            miso_q, miso_d;
  logic            done_q, done_d;
  logic            underrun_q, underrun_d;
  logic            abort_q, abort_d;
  logic            completing;

  // A word accepted in the same cycle as cs_fall stays buffered for the next transfer,
  // because the consume test looks only at the registered hold_full_q.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_reg_d = shift_reg_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    done_d      = 1'b0;
    underrun_d  = 1'b0;
    abort_d     = 1'b0;
    completing  = 1'b0;

    if (tx.tx_valid && !hold_full_q) begin
      hold_data_d = tx.tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          if (hold_full_q) begin
            shift_reg_d = hold_data_q;
            hold_full_d = 1'b0;
          end else begin
            shift_reg_d = '0;
            underrun_d  = 1'b1;
          end
          count_d = '0;
          state_d = ACTIVE;
        end
      end
      default: begin
        if (sck_rise) begin
          count_d     = count_q + 1'b1;
          shift_reg_d = {shift_reg_q[BITS-2:0], 1'b0};
          if (count_q == LAST) begin
            completing = 1'b1;
            done_d     = 1'b1;
            state_d    = IDLE;
          end
        end
        if (cs_rise && !completing) begin
          abort_d     = 1'b1;
          shift_reg_d = '0;
          state_d     = IDLE;
        end
      end
    endcase

    miso_d = shift_reg_d[BITS-1] ^ MISO_INV;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shift_reg_q <= '0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      miso_q      <= MISO_INV;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_reg_q <= shift_reg_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      miso_q      <= miso_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
    end
  end

  assign tx.tx_ready = !hold_full_q;
  assign miso        = miso_q;
  assign busy        = (state_q == ACTIVE);
  assign done        = done_q;
  assign underrun    = underrun_q;
  assign abort       = abort_q;

endmodule

// File: tb/tb_spi_slave_out.sv
// Directed bench for spi_slave_out: acts as a CPOL=1 SPI master sampling miso on sck rise.
// With SPI_SLAVE_MISO_INVERT_EN the master captures the inverted line.
module tb_spi_slave_out;

  localparam int BITS = 4;
  localparam int HALF = 4;
`ifdef SPI_SLAVE_MISO_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sck = 1'b1;
  logic cs = 1'b1;
  logic miso, busy, done, underrun, abort;

  int checks = 0;
  int fails = 0;
  int done_cnt = 0;
  int underrun_cnt = 0;
  int abort_cnt = 0;
  logic [BITS-1:0] cap;

  spi_slave_out_if #(.BITS(BITS)) tx ();

  spi_slave_out #(.BITS(BITS), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .tx(tx), .sck(sck), .cs(cs),
    .miso(miso), .busy(busy), .done(done), .underrun(underrun), .abort(abort)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge, away from the DUT's active edge
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (underrun) underrun_cnt++;
    if (abort) abort_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearCounts();
    done_cnt = 0;
    underrun_cnt = 0;
    abort_cnt = 0;
  endtask

  // Offer one word on the load channel, waiting a bounded time for room
  task automatic applyStimulus(input logic [BITS-1:0] w);
    int n = 0;
    while (!tx.tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!tx.tx_ready) checkOutput("load_ready_timeout", 32'(tx.tx_ready), 32'd1);
    tx.tx_data  = w;
    tx.tx_valid = 1'b1;
    @(negedge clk);
    tx.tx_valid = 1'b0;
  endtask

  // Drop cs and clock nrise bits; optionally load a word during the second low phase
  task automatic spiTransfer(input int nrise, input logic load_en, input logic [BITS-1:0] load_word,
                             output logic [BITS-1:0] got);
    got = '0;
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nrise; i++) begin
      sck = 1'b0;
      if (load_en && i == 1) begin
        tx.tx_data  = load_word;
        tx.tx_valid = 1'b1;
        @(negedge clk);
        tx.tx_valid = 1'b0;
        repeat (HALF - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      got = {got[BITS-2:0], miso ^ INV};
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic endTransfer();
    cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    tx.tx_data  = '0;
    tx.tx_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_tx_ready", 32'(tx.tx_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_miso", 32'(miso), 32'(INV));
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_miso", 32'(miso), 32'(INV));
    clearCounts();

    // Normal word 1011
    applyStimulus(4'b1011);
    checkOutput("load_ready_low", 32'(tx.tx_ready), 32'd0);
    spiTransfer(4, 1'b0, '0, cap);
    checkOutput("normal_data", 32'(cap), 32'hB);
    endTransfer();
    checkOutput("normal_done", 32'(done_cnt), 32'd1);
    checkOutput("normal_busy", 32'(busy), 32'd0);
    checkOutput("normal_ready", 32'(tx.tx_ready), 32'd1);
    checkOutput("normal_underrun", 32'(underrun_cnt), 32'd0);

    // Underrun: no word loaded
    clearCounts();
    spiTransfer(4, 1'b0, '0, cap);
    checkOutput("under_data", 32'(cap), 32'h0);
    endTransfer();
    checkOutput("under_pulse", 32'(underrun_cnt), 32'd1);
    checkOutput("under_done", 32'(done_cnt), 32'd1);

    // Preload 5, load A mid-transfer, back-to-back with a 1-clk cs high gap
    clearCounts();
    applyStimulus(4'h5);
    spiTransfer(4, 1'b1, 4'hA, cap);
    checkOutput("b2b_first", 32'(cap), 32'h5);
    checkOutput("b2b_ready_low", 32'(tx.tx_ready), 32'd0);
    cs = 1'b1;
    @(negedge clk);
    spiTransfer(4, 1'b0, '0, cap);
    checkOutput("b2b_second", 32'(cap), 32'hA);
    endTransfer();
    checkOutput("b2b_done", 32'(done_cnt), 32'd2);
    checkOutput("b2b_underrun", 32'(underrun_cnt), 32'd0);

    // Abort after 2 rises, with a word loaded during the aborted transfer
    clearCounts();
    applyStimulus(4'h9);
    spiTransfer(2, 1'b1, 4'h6, cap);
    checkOutput("abort_bits", 32'(cap), 32'h2);
    endTransfer();
    checkOutput("abort_pulse", 32'(abort_cnt), 32'd1);
    checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_idle_miso", 32'(miso), 32'(INV));
    clearCounts();
    spiTransfer(4, 1'b0, '0, cap);
    checkOutput("post_abort_data", 32'(cap), 32'h6);
    endTransfer();
    checkOutput("post_abort_done", 32'(done_cnt), 32'd1);
    checkOutput("post_abort_under", 32'(underrun_cnt), 32'd0);

    // Reset asserted mid-transfer
    applyStimulus(4'hF);
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
    repeat (HALF) @(negedge clk);
    sck = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_ready", 32'(tx.tx_ready), 32'd1);
    checkOutput("mid_rst_miso", 32'(miso), 32'(INV));
    checkOutput("mid_rst_pulses", 32'({done, underrun, abort}), 32'd0);
    cs = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rel_miso", 32'(miso), 32'(INV));
    checkOutput("rel_ready", 32'(tx.tx_ready), 32'd1);
    checkOutput("rel_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave_out.md
Name: spi_slave_out

Overview:
- SPI slave transmitter: responds to an external SPI master by shifting a parallel word out on miso, MSB first.
- Protocol: CPOL=1 (sck idles high), cs active-low. The master samples miso on each sck rising edge, and a word is BITS rising edges long.
- sck/cs come from off-chip or from another block, so they are synchronised into clk.
- Local logic loads words through a one-deep valid/ready holding buffer.

Parameters:
- BITS, 4, word length in bits (>=2).
- SYNC_STAGES, 2, synchroniser flops on sck and cs (>=2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset: asserted when 0, released synchronously to clk.
- tx_data  input  BITS  word to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  holding buffer empty; a word is accepted when tx_valid && tx_ready.
- sck  input  1  SPI clock from the master, asynchronous.
- cs  input  1  SPI chip select from the master, active-low, asynchronous.
- miso  output  1  serial data to the master (registered).
- busy  output  1  a transaction is in progress (state != IDLE).
- done  output  1  one-clk pulse when all BITS bits have been shifted.
- underrun  output  1  one-clk pulse when a transaction starts with the holding buffer empty.
- abort  output  1  one-clk pulse when cs rises before BITS rising edges.

Behaviour:
- Reset values:
  - tx_ready=1, busy=0, done=0, underrun=0, abort=0.
  - miso=0; shift_reg=0; hold_full=0; count=0; state=IDLE.
  - Synchroniser flops reset to 1, the idle level, so no edge is seen after reset.
- Synchronisers and edge detection:
  - sck_s and cs_s are SYNC_STAGES-flop synchronised copies of sck and cs.
  - A prev flop on each gives single-clk strobes: sck_rise, cs_fall, cs_rise.
- Holding buffer:
  - tx_ready = !hold_full.
  - On accept: hold_data <= tx_data and hold_full <= 1. Accepted in any state.
  - hold_full clears only when the word is consumed at a cs_fall.
- State IDLE:
  - miso = shift_reg[BITS-1].
  - On cs_fall with hold_full=1: shift_reg <= hold_data; hold_full <= 0.
  - On cs_fall with hold_full=0: shift_reg <= 0; underrun pulse.
  - On cs_fall: count <= 0 and go to ACTIVE.
  - miso reflects the new MSB on the next clk, before the master's first sample.
  - Accept and cs_fall in the same cycle: the new word is not used for this transaction. It stays in the buffer, and underrun still fires if the buffer was empty.
- State ACTIVE:
  - On sck_rise: count <= count+1 and shift_reg <= shift_reg<<1 (zero fill). miso follows the new MSB.
  - When count+1 == BITS: done pulse and go to IDLE.
  - On cs_rise with count < BITS and no completing sck_rise in the same cycle: abort pulse, go to IDLE, shift_reg <= 0.
  - sck_rise and cs_rise in the same cycle: process the edge first. If it completes the word, done fires and abort does not.
- Back-to-back: a cs high pulse of >=1 clk between words must be detected. No glitch filter.
- Timing requirement on the master: sck half-period >= SYNC_STAGES+2 clk. The synced sample-to-shift latency is SYNC_STAGES+1 clk.
- count width: $clog2(BITS+1).

Optional Feature:
- Macro: SPI_SLAVE_MISO_INVERT_EN.
- Defined: miso is driven as the complement of shift_reg[BITS-1], with reset/idle value 1. This matches a master that captures the inverted line, so that master receives tx_data unmodified.
- Undefined: miso is driven true.

Decomposition:
- Package spi_pkg holds:
  - SCK_IDLE=1'b1 and CS_IDLE=1'b1.
  - State encoding IDLE/ACTIVE.
  - Default BITS and SYNC_STAGES constants.
- Sub-module sync_edge: SYNC_STAGES-flop synchroniser with prev flop. Outputs level, rise and fall; reset value is a parameter. Instantiated for sck and cs.

Test Plan:
- Reset: reset=0 mid-transfer -> all outputs at reset values immediately; after release, miso=0, tx_ready=1, busy=0.
- Normal word: load 4'b1011, then master transfer with half-period 4 clk -> miso at the four sck rises = 1,0,1,1; done pulses once; busy falls; tx_ready=1.
- Underrun: cs falls with no load -> underrun pulse; bits 0,0,0,0; done still pulses.
- Preload/back-to-back: load 4'h5, start; load 4'hA during the transfer (tx_ready=0 after); cs high for 1 clk -> second word 1,0,1,0; no underrun.
- Abort: cs rises after 2 sck rises -> abort pulse, no done, state IDLE; the next transaction sends the next held word, or underruns.
- Macro defined, paired with an inverting-capture SPI master, BITS=4: tx 4'h6 -> master captures 4'h6; miso idle=1 after reset.
